// File: rtl/clkgen_cfg_sequencer_pkg.sv
// rtl/clkgen_cfg_sequencer_pkg.sv - shared types, ring constants and pattern check for the clock-generator config sequencer
package clkgen_cfg_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_IDLE,
        ST_CHECK,
        ST_WAIT_WRAP,
        ST_LOAD,
        ST_SETTLE
    } state_t;

    localparam int RING_LEN   = 32;
    localparam int TAP_OFFSET = 16;

    // The two output taps sit TAP_OFFSET apart on the ring; any shared bit means overlapping outputs.
    function automatic logic pattern_ok(input logic [RING_LEN-1:0] p);
        logic [RING_LEN-1:0] rot;
        rot = (p >> TAP_OFFSET) | (p << (RING_LEN - TAP_OFFSET));
        return (p != '0) && ((p & rot) == '0);
    endfunction

endpackage

// File: rtl/clkgen_cfg_sequencer_pattern_check.sv
// rtl/clkgen_cfg_sequencer_pattern_check.sv - combinational validity check of a staged ring pattern
module clkgen_pattern_check
    import clkgen_cfg_sequencer_pkg::*;
(
    input  logic [RING_LEN-1:0] pattern,
    output logic                valid
);

    assign valid = pattern_ok(pattern);

endmodule

// File: rtl/clkgen_cfg_sequencer.sv
// rtl/clkgen_cfg_sequencer.sv - sequences ring-pattern/phase reconfiguration of the clock generator onto ring boundaries
module clkgen_cfg_sequencer
    import clkgen_cfg_sequencer_pkg::*;
#(
    parameter int          STARTUP_CYCLES  = 1000,
    parameter logic [31:0] DEFAULT_PATTERN = 32'h00007FFE,
    parameter logic [4:0]  DEFAULT_PHASE   = 5'd16,
    parameter int          SETTLE_CYCLES   = 32
) (
    input  logic        CLK_IN,
    input  logic        RESET_N,
    input  logic        CFG_VALID,
    output logic        CFG_READY,
    input  logic [31:0] CFG_PATTERN,
    input  logic [4:0]  CFG_PHASE,
    output logic [31:0] SET,
    output logic [4:0]  PHASE_SEL,
    output logic        SR_LOAD,
    output logic        LOCKED,
    output logic        CFG_ERR
);

    localparam logic [31:0] STARTUP_LAST = 32'(STARTUP_CYCLES - 1);
    localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
    localparam logic [4:0]  POS_LAST     = 5'(RING_LEN - 1);

    state_t      state;
    logic [31:0] cnt;
    logic [4:0]  pos;
    logic [31:0] staged_pattern;
    logic [4:0]  staged_phase;
    logic        pattern_valid;

    clkgen_pattern_check u_check (
        .pattern (staged_pattern),
        .valid   (pattern_valid)
    );

    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            state          <= ST_STARTUP;
            cnt            <= '0;
            pos            <= '0;
            staged_pattern <= '0;
            staged_phase   <= '0;
            SR_LOAD        <= 1'b1;
            SET            <= DEFAULT_PATTERN;
            PHASE_SEL      <= DEFAULT_PHASE;
            CFG_READY      <= 1'b0;
            LOCKED         <= 1'b0;
            CFG_ERR        <= 1'b0;
        end else begin
            CFG_ERR <= 1'b0;
            // Ring position restarts from 0 whenever the generator is being loaded.
            pos     <= SR_LOAD ? 5'd0 : pos + 5'd1;

            case (state)
                ST_STARTUP: begin
                    if (cnt == STARTUP_LAST) begin
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        SR_LOAD   <= 1'b0;
                        CFG_READY <= 1'b1;
                        LOCKED    <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_IDLE: begin
                    if (CFG_VALID && CFG_READY) begin
                        staged_pattern <= CFG_PATTERN;
                        staged_phase   <= CFG_PHASE;
                        CFG_READY      <= 1'b0;
                        state          <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (pattern_valid) begin
                        state  <= ST_WAIT_WRAP;
                        LOCKED <= 1'b0;
                    end else begin
                        state     <= ST_IDLE;
                        CFG_ERR   <= 1'b1;
                        CFG_READY <= 1'b1;
                    end
                end
                ST_WAIT_WRAP: begin
                    if (pos == POS_LAST) begin
                        state     <= ST_LOAD;
                        SR_LOAD   <= 1'b1;
                        SET       <= staged_pattern;
                        PHASE_SEL <= staged_phase;
                    end
                end
                ST_LOAD: begin
                    state   <= ST_SETTLE;
                    SR_LOAD <= 1'b0;
                    cnt     <= '0;
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        CFG_READY <= 1'b1;
                        LOCKED    <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    state   <= ST_STARTUP;
                    cnt     <= '0;
                    SR_LOAD <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clkgen_cfg_sequencer.sv
// tb/tb_clkgen_cfg_sequencer.sv - randomized self-checking bench for clkgen_cfg_sequencer
module tb_clkgen_cfg_sequencer;

    localparam int          STARTUP = 1000;
    localparam int          SETTLE  = 32;
    localparam logic [31:0] DEF_PAT = 32'h00007FFE;
    localparam logic [4:0]  DEF_PH  = 5'd16;

    logic        CLK_IN = 1'b0;
    logic        RESET_N;
    logic        CFG_VALID;
    logic        CFG_READY;
    logic [31:0] CFG_PATTERN;
    logic [4:0]  CFG_PHASE;
    logic [31:0] SET;
    logic [4:0]  PHASE_SEL;
    logic        SR_LOAD;
    logic        LOCKED;
    logic        CFG_ERR;

    int          vectors = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          base    = 0;
    logic [31:0] m_set;
    logic [4:0]  m_phase;

    always #5 CLK_IN = ~CLK_IN;

    clkgen_cfg_sequencer #(
        .STARTUP_CYCLES  (STARTUP),
        .DEFAULT_PATTERN (DEF_PAT),
        .DEFAULT_PHASE   (DEF_PH),
        .SETTLE_CYCLES   (SETTLE)
    ) dut (
        .CLK_IN      (CLK_IN),
        .RESET_N     (RESET_N),
        .CFG_VALID   (CFG_VALID),
        .CFG_READY   (CFG_READY),
        .CFG_PATTERN (CFG_PATTERN),
        .CFG_PHASE   (CFG_PHASE),
        .SET         (SET),
        .PHASE_SEL   (PHASE_SEL),
        .SR_LOAD     (SR_LOAD),
        .LOCKED      (LOCKED),
        .CFG_ERR     (CFG_ERR)
    );

    task automatic tick();
        @(posedge CLK_IN);
        #1;
        cyc++;
    endtask

    // Bit-by-bit: a pattern is legal if non-empty and no bit has a partner half a ring away.
    function automatic bit ref_ok(input logic [31:0] p);
        bit any   = 1'b0;
        bit clash = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (p[i]) any = 1'b1;
            if (p[i] && p[(i + 16) % 32]) clash = 1'b1;
        end
        return any && !clash;
    endfunction

    function automatic logic [31:0] gen_pattern();
        logic [15:0] r;
        logic [31:0] w;
        r = 16'($urandom);
        w = {16'h0, r};
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return w;
            2:       return w << $urandom_range(0, 15);
            default: return ($urandom_range(0, 1) == 0) ? 32'h0 : 32'h00018001;
        endcase
    endfunction

    task automatic test_reset();
        int rel;
        int fall = -1;
        int bad  = 0;
        RESET_N   = 1'b0;
        CFG_VALID = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({SR_LOAD, CFG_READY, LOCKED, CFG_ERR} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=1000", {SR_LOAD, CFG_READY, LOCKED, CFG_ERR});
        end
        vectors++;
        if (SET !== DEF_PAT || PHASE_SEL !== DEF_PH) begin
            errors++;
            $display("FAIL reset_cfg got=%h/%0d exp=%h/%0d", SET, PHASE_SEL, DEF_PAT, DEF_PH);
        end
        RESET_N = 1'b1;
        rel = cyc;
        for (int k = 0; k < STARTUP + 10 && fall < 0; k++) begin
            tick();
            if (SR_LOAD === 1'b0) fall = cyc - rel;
            else if (CFG_READY !== 1'b0 || LOCKED !== 1'b0 || SET !== DEF_PAT) bad++;
        end
        vectors++;
        if (fall != STARTUP) begin
            errors++;
            $display("FAIL startup_len got=%0d exp=%0d", fall, STARTUP);
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL startup_hold got=%0d bad cycles exp=0", bad);
        end
        vectors++;
        if (LOCKED !== 1'b1 || CFG_READY !== 1'b1 || SET !== DEF_PAT || PHASE_SEL !== DEF_PH) begin
            errors++;
            $display("FAIL startup_done got=lk%b rdy%b %h/%0d exp=lk1 rdy1 %h/%0d",
                     LOCKED, CFG_READY, SET, PHASE_SEL, DEF_PAT, DEF_PH);
        end
        base    = cyc;
        m_set   = DEF_PAT;
        m_phase = DEF_PH;
    endtask

    // Offers one configuration from IDLE and follows it until the sequencer is idle again.
    task automatic do_cfg(input logic [31:0] p, input logic [4:0] ph, input bit hold_valid);
        int          h;
        int          exp_load;
        logic        exp_on;
        logic [31:0] exp_set;
        logic [4:0]  exp_ph;
        vectors++;
        if (CFG_READY !== 1'b1) begin
            errors++;
            $display("FAIL ready_at_offer got=%b exp=1", CFG_READY);
        end
        CFG_VALID   = 1'b1;
        CFG_PATTERN = p;
        CFG_PHASE   = ph;
        tick();
        h = cyc;
        if (hold_valid) begin
            CFG_PATTERN = gen_pattern();
            CFG_PHASE   = 5'($urandom);
        end else begin
            CFG_VALID = 1'b0;
        end
        vectors++;
        if (CFG_READY !== 1'b0 || CFG_ERR !== 1'b0 || LOCKED !== 1'b1 || SR_LOAD !== 1'b0) begin
            errors++;
            $display("FAIL check_cycle got=rdy%b err%b lk%b ld%b exp=rdy0 err0 lk1 ld0",
                     CFG_READY, CFG_ERR, LOCKED, SR_LOAD);
        end
        if (!ref_ok(p)) begin
            tick();
            if (hold_valid) begin
                CFG_PATTERN = gen_pattern();
                CFG_PHASE   = 5'($urandom);
            end
            vectors++;
            if (CFG_ERR !== 1'b1 || SR_LOAD !== 1'b0 || CFG_READY !== 1'b1 || LOCKED !== 1'b1 ||
                SET !== m_set || PHASE_SEL !== m_phase) begin
                errors++;
                $display("FAIL reject p=%h got=err%b ld%b rdy%b lk%b %h/%0d exp=err1 ld0 rdy1 lk1 %h/%0d",
                         p, CFG_ERR, SR_LOAD, CFG_READY, LOCKED, SET, PHASE_SEL, m_set, m_phase);
            end
            return;
        end
        exp_load = h + 2;
        while (((exp_load - 1 - base) % 32) != 31) exp_load++;
        for (int e = h + 1; e <= exp_load + 1 + SETTLE; e++) begin
            tick();
            if (hold_valid) begin
                CFG_PATTERN = gen_pattern();
                CFG_PHASE   = 5'($urandom);
            end
            exp_on  = (cyc >= exp_load + 1 + SETTLE);
            exp_set = (cyc >= exp_load) ? p : m_set;
            exp_ph  = (cyc >= exp_load) ? ph : m_phase;
            vectors++;
            if (SR_LOAD !== (cyc == exp_load) || LOCKED !== exp_on || CFG_READY !== exp_on ||
                CFG_ERR !== 1'b0 || SET !== exp_set || PHASE_SEL !== exp_ph) begin
                errors++;
                $display("FAIL accept p=%h cyc+%0d got=ld%b lk%b rdy%b err%b %h/%0d exp=ld%b lk%b rdy%b err0 %h/%0d",
                         p, cyc - h, SR_LOAD, LOCKED, CFG_READY, CFG_ERR, SET, PHASE_SEL,
                         (cyc == exp_load), exp_on, exp_on, exp_set, exp_ph);
            end
        end
        m_set   = p;
        m_phase = ph;
        base    = exp_load + 1;
    endtask

    task automatic test_directed();
        do_cfg(32'h00003FFC, 5'd8, 1'b0);
        do_cfg(32'h00018001, 5'd3, 1'b0);
        do_cfg(32'h00000000, 5'd4, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) do_cfg(gen_pattern(), 5'($urandom), 1'b0);
    endtask

    task automatic test_same_config();
        do_cfg(m_set, m_phase, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) do_cfg(gen_pattern(), 5'($urandom), 1'b1);
        do_cfg(32'h000000F0, 5'd1, 1'b0);
    endtask

    task automatic test_reset_mid_wait();
        int bad = 0;
        CFG_VALID   = 1'b1;
        CFG_PATTERN = 32'h0000ABCD;
        CFG_PHASE   = 5'd27;
        tick();
        CFG_VALID = 1'b0;
        tick();
        vectors++;
        if (LOCKED !== 1'b0 || SR_LOAD !== 1'b0) begin
            errors++;
            $display("FAIL wait_wrap_entry got=lk%b ld%b exp=lk0 ld0", LOCKED, SR_LOAD);
        end
        RESET_N = 1'b0;
        #1;
        vectors++;
        if ({SR_LOAD, CFG_READY, LOCKED, CFG_ERR} !== 4'b1000 || SET !== DEF_PAT || PHASE_SEL !== DEF_PH) begin
            errors++;
            $display("FAIL async_reset got=%b %h/%0d exp=1000 %h/%0d",
                     {SR_LOAD, CFG_READY, LOCKED, CFG_ERR}, SET, PHASE_SEL, DEF_PAT, DEF_PH);
        end
        test_reset();
        for (int k = 0; k < 80; k++) begin
            tick();
            if (SR_LOAD !== 1'b0 || SET !== DEF_PAT || PHASE_SEL !== DEF_PH || LOCKED !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stale_load got=%0d bad cycles exp=0", bad);
        end
    endtask

    initial begin
        RESET_N     = 1'b0;
        CFG_VALID   = 1'b0;
        CFG_PATTERN = '0;
        CFG_PHASE   = '0;
        test_reset();
        test_directed();
        test_random();
        test_same_config();
        test_back_to_back();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
